xnor_neuron_seq: RTL and testbench
==================================

Name: xnor_neuron_seq

Overview:
- Sequencer for one binarised neuron built on the xnor_popcount datapath.
- On start, it walks the activation/weight/threshold memories chunk by chunk and issues one read per cycle.
- It accumulates the popcount returned by the pipelined datapath after a fixed latency.
- It compares the total against a latched threshold and presents the result through a valid/ready handshake to the layer controller.

Parameters:
- N, 128, chunk width in bits fed to the popcount datapath.
- D, $clog2(N)+1, width of the popcount result per chunk.
- POP, 16, accumulator and threshold width.
- AW, 3, memory address width; up to 2^AW chunks per neuron.
- LAT, 3, cycles from mem_re asserted to the matching pop_in being valid; must be >= 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-high.
- start  in  1  begin one neuron evaluation; sampled only in IDLE.
- num_chunks  in  AW+1  chunks to process, 0..2^AW; latched at start.
- threshold  in  POP  compare value; latched at start.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  AW  chunk address to the x/w memories.
- mem_re  out  1  read strobe; one chunk issued per cycle while high.
- pop_in  in  D  popcount from the datapath, valid LAT cycles after the matching mem_re.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_out  out  1  1 when sum > threshold (strict compare).
- result_sum  out  POP  final accumulated popcount.

Behaviour:
- Reset (rstn=1 at a clk edge), applied from any state:
  - State goes to IDLE.
  - All outputs go to 0: busy, mem_re, mem_addr, result_valid, result_out, result_sum.
  - Accumulator, issue counter and return counter clear.
  - The LAT-deep valid shift register clears, so pop_in values from reads issued before reset are never accumulated.
- State machine:
  - States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE, start=1, num_chunks>0: latch K=num_chunks and threshold, clear the accumulator and both counters, go to ISSUE.
  - IDLE, start=1, num_chunks=0: latch threshold, set accumulator to 0, go directly to DONE (sum 0, out = 0 > threshold, which is 0).
  - ISSUE: mem_re=1 and mem_addr=issue counter, counting 0..K-1. After the cycle with addr K-1, go to DRAIN. Reads are issued on consecutive cycles with no gaps.
  - DRAIN: mem_re=0, mem_addr holds its last value. When the return counter reaches K, go to DONE.
  - DONE: result_valid=1, with result_sum and result_out stable. When result_valid and result_ready are both high at an edge, return to IDLE; result_valid drops next cycle. While result_ready=0, hold indefinitely.
- Return path:
  - mem_re is shifted through the LAT-stage valid pipe.
  - When the pipe output is 1, acc <= acc + zero-extended pop_in and the return counter increments.
  - pop_in is ignored whenever the pipe output is 0.
- Arithmetic:
  - acc is POP bits and saturates at 2^POP-1 instead of wrapping.
  - result_out is registered on entry to DONE as (acc_final > threshold), unsigned.
- Latency: for K>0, with the start-accept edge at cycle 0:
  - mem_re is high in cycles 1..K.
  - The last accumulation happens at edge K+LAT.
  - result_valid is first high in cycle K+LAT+1.
  - For K=0, result_valid is high in cycle 1.
- Boundary and simultaneous events:
  - start while busy=1 is ignored, and num_chunks/threshold are not re-latched.
  - start and result handshake in the same DONE cycle: the return to IDLE wins; start must be reasserted in IDLE.
  - Back-to-back neurons: start may be asserted in the first IDLE cycle after the handshake.
  - K=2^AW: the address wraps cleanly, and the last address is 2^AW-1.
  - Changes to threshold or num_chunks after start have no effect on the current evaluation.

Test Plan:
- Reset then idle: rstn=1 for 2 cycles, start=0 -> all outputs 0, busy=0, mem_re never high.
- Nominal: K=4, threshold=200, datapath model returns 64 per chunk, LAT=3 -> mem_addr 0,1,2,3 in cycles 1-4; result_valid in cycle 8; result_sum=256, result_out=1.
- Equal compare and backpressure: K=2, pop_in=100 each, threshold=200, result_ready held 0 for 5 cycles -> result_sum=200, result_out=0, result_valid held high and stable until ready, then IDLE next cycle.
- Zero/full chunk counts:
  - K=0, threshold=0 -> result_valid in cycle 1, sum=0, out=0, mem_re never high.
  - K=8, pop_in=128 each -> addr wraps 0..7, sum=1024, out=1 for threshold=1000.
- Start while busy: assert start again during ISSUE with num_chunks=1, threshold=0 -> ignored; the original K and threshold produce the result, and exactly K reads are issued.
- Reset mid-operation: K=8, rstn=1 in cycle 5 while pop_in keeps returning 50 -> IDLE, outputs 0. A new start with K=1 and pop_in=7 gives result_sum=7, with no stale accumulation.

Source files
------------

// File: rtl/xnor_neuron_seq.sv
// Sequencer for one binarised neuron: issues chunk reads, accumulates the
// delayed popcounts from the xnor_popcount datapath and thresholds the total.
module xnor_neuron_seq #(
   parameter int N   = 128,
   parameter int D   = $clog2(N) + 1,
   parameter int POP = 16,
   parameter int AW  = 3,
   parameter int LAT = 3
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic [AW:0]    num_chunks,
   input  logic [POP-1:0] threshold,
   output logic           busy,
   output logic [AW-1:0]  mem_addr,
   output logic           mem_re,
   input  logic [D-1:0]   pop_in,
   output logic           result_valid,
   input  logic           result_ready,
   output logic           result_out,
   output logic [POP-1:0] result_sum
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t         state_reg, state_next;
   logic [AW:0]    k_reg;
   logic [POP-1:0] thr_reg;
   logic [POP-1:0] acc_reg, acc_next, acc_sat;
   logic [POP:0]   acc_wide;
   logic [POP-1:0] sum_reg;
   logic           out_reg;
   logic [AW-1:0]  issue_cnt_reg;
   logic [AW:0]    ret_cnt_reg, ret_cnt_next;
   logic [LAT-1:0] vpipe_reg;
   logic [LAT:0]   vpipe_ext;
   logic           pipe_out;
   logic           last_issue;
   logic           start_accept;

   assign start_accept = (state_reg == IDLE) && start;
   assign last_issue   = ({1'b0, issue_cnt_reg} == (k_reg - {{AW{1'b0}}, 1'b1}));

   // Read strobes travel down this pipe so each returning pop_in is matched to a read.
   assign vpipe_ext = {vpipe_reg, mem_re};
   assign pipe_out  = vpipe_reg[LAT-1];

   assign acc_wide     = {1'b0, acc_reg} + {{(POP + 1 - D){1'b0}}, pop_in};
   assign acc_sat      = acc_wide[POP] ? {POP{1'b1}} : acc_wide[POP-1:0];
   assign acc_next     = pipe_out ? acc_sat : acc_reg;
   assign ret_cnt_next = ret_cnt_reg + {{AW{1'b0}}, pipe_out};

   assign mem_addr   = issue_cnt_reg;
   assign result_out = out_reg;
   assign result_sum = sum_reg;

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      busy         = 1'b1;
      mem_re       = 1'b0;
      result_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = (num_chunks == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            mem_re = 1'b1;
            if (last_issue) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Exit on the edge that performs the final accumulation.
            if (ret_cnt_next == k_reg) begin
               state_next = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         k_reg         <= '0;
         thr_reg       <= '0;
         acc_reg       <= '0;
         sum_reg       <= '0;
         out_reg       <= 1'b0;
         issue_cnt_reg <= '0;
         ret_cnt_reg   <= '0;
         vpipe_reg     <= '0;
      end else begin
         vpipe_reg <= vpipe_ext[LAT-1:0];
         if (start_accept) begin
            k_reg         <= num_chunks;
            thr_reg       <= threshold;
            acc_reg       <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            if (num_chunks == '0) begin
               sum_reg <= '0;
               out_reg <= 1'b0;
            end
         end else begin
            if (pipe_out) begin
               acc_reg     <= acc_next;
               ret_cnt_reg <= ret_cnt_next;
            end
            // The counter stops on the last address so mem_addr holds through DRAIN.
            if (state_reg == ISSUE && !last_issue) begin
               issue_cnt_reg <= issue_cnt_reg + {{(AW-1){1'b0}}, 1'b1};
            end
            if (state_reg == DRAIN && state_next == DONE) begin
               sum_reg <= acc_next;
               out_reg <= (acc_next > thr_reg);
            end
         end
      end
   end

endmodule

// File: tb/tb_xnor_neuron_seq.sv
// Self-checking bench for xnor_neuron_seq: vector table plus reset corner cases,
// with a delayed-return datapath model and a result scoreboard.
module tb_xnor_neuron_seq;
   localparam int N   = 128;
   localparam int D   = $clog2(N) + 1;
   localparam int POP = 16;
   localparam int AW  = 3;
   localparam int LAT = 3;
   localparam int NV  = 9;

   logic           clk = 1'b0;
   logic           rstn;
   logic           start;
   logic [AW:0]    num_chunks;
   logic [POP-1:0] threshold;
   logic           busy;
   logic [AW-1:0]  mem_addr;
   logic           mem_re;
   logic [D-1:0]   pop_in;
   logic           result_valid;
   logic           result_ready;
   logic           result_out;
   logic [POP-1:0] result_sum;

   xnor_neuron_seq #(.N(N), .D(D), .POP(POP), .AW(AW), .LAT(LAT)) dut (
      .clk(clk), .rstn(rstn), .start(start), .num_chunks(num_chunks),
      .threshold(threshold), .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re),
      .pop_in(pop_in), .result_valid(result_valid), .result_ready(result_ready),
      .result_out(result_out), .result_sum(result_sum)
   );

   always #5 clk = ~clk;

   typedef struct {
      int k; int thr; int pop; int delay; bit poke; bit start_hs; int exp_sum; bit exp_out;
   } vec_t;
   typedef struct { int sum; bit out; } exp_t;

   int       n_checks = 0;
   int       n_errors = 0;
   exp_t     sb_q[$];
   vec_t     vecs [NV];
   logic [D-1:0] mem_val  [(1<<AW)];
   logic [D-1:0] hist_val [LAT];
   logic         hist_v   [LAT];
   int           idle_pop = -1;

   // Datapath model: value captured at the read, returned LAT cycles later.
   always @(negedge clk) begin
      if (hist_v[LAT-1]) pop_in = hist_val[LAT-1];
      else if (idle_pop >= 0) pop_in = D'(idle_pop);
      else pop_in = D'($urandom_range(0, 255));
      for (int i = LAT - 1; i > 0; i--) begin
         hist_v[i]   = hist_v[i-1];
         hist_val[i] = hist_val[i-1];
      end
      hist_v[0]   = (mem_re === 1'b1);
      hist_val[0] = mem_val[mem_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_re"},    int'(mem_re), 0);
      chk({tag, "_addr"},  int'(mem_addr), 0);
      chk({tag, "_valid"}, int'(result_valid), 0);
      chk({tag, "_out"},   int'(result_out), 0);
      chk({tag, "_sum"},   int'(result_sum), 0);
   endtask

   // Called at a negedge in IDLE; returns at a negedge in IDLE.
   task automatic run_neuron(input vec_t v);
      int   cyc, first_valid, exp_lat, n_reads;
      exp_t e;
      for (int i = 0; i < (1 << AW); i++) mem_val[i] = D'(v.pop);
      start      = 1'b1;
      num_chunks = (AW+1)'(v.k);
      threshold  = POP'(v.thr);
      sb_q.push_back('{v.exp_sum, v.exp_out});
      @(negedge clk);
      start      = 1'b0;
      num_chunks = (AW+1)'($urandom_range(0, 8));
      threshold  = POP'($urandom);
      exp_lat    = (v.k == 0) ? 1 : v.k + LAT + 1;
      cyc = 1; first_valid = -1; n_reads = 0;
      while (cyc <= 40) begin
         if (v.poke && cyc == 2) begin
            start = 1'b1; num_chunks = 1; threshold = 0;
         end else if (v.poke && cyc == 3) begin
            start = 1'b0;
         end
         chk("rd_strobe", int'(mem_re), int'(cyc >= 1 && cyc <= v.k));
         if (mem_re === 1'b1) begin
            n_reads++;
            chk("rd_addr", int'(mem_addr), cyc - 1);
         end
         if (result_valid === 1'b1) begin
            first_valid = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      chk("valid_latency", first_valid, exp_lat);
      chk("read_count", n_reads, v.k);
      if (first_valid < 0) return;
      for (int d = 0; d < v.delay; d++) begin
         chk("hold_valid", int'(result_valid), 1);
         chk("hold_sum", int'(result_sum), v.exp_sum);
         chk("hold_out", int'(result_out), int'(v.exp_out));
         @(negedge clk);
      end
      result_ready = 1'b1;
      if (v.start_hs) start = 1'b1;
      chk("hs_valid", int'(result_valid), 1);
      chk("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("result_sum", int'(result_sum), e.sum);
         chk("result_out", int'(result_out), int'(e.out));
      end
      $display("neuron k=%0d thr=%0d pop=%0d -> sum=%0d out=%0d latency=%0d",
               v.k, v.thr, v.pop, result_sum, result_out, first_valid);
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
      chk("post_hs_busy", int'(busy), 0);
      chk("post_hs_valid", int'(result_valid), 0);
      if (v.start_hs) begin
         @(negedge clk);
         chk("start_in_done_ignored", int'(busy), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < LAT; i++) begin
         hist_v[i] = 1'b0; hist_val[i] = '0;
      end
      for (int i = 0; i < (1 << AW); i++) mem_val[i] = '0;
      rstn = 1'b1; start = 1'b0; num_chunks = '0; threshold = '0; result_ready = 1'b0;

      //            k  thr   pop  dly poke hs  sum   out
      vecs[0] = '{4, 200,  64,  0, 0, 0, 256,  1};
      vecs[1] = '{2, 200,  100, 5, 0, 0, 200,  0};
      vecs[2] = '{0, 0,    0,   0, 0, 0, 0,    0};
      vecs[3] = '{8, 1000, 128, 2, 0, 0, 1024, 1};
      vecs[4] = '{3, 100,  40,  0, 1, 0, 120,  1};
      vecs[5] = '{8, 1024, 128, 0, 0, 1, 1024, 0};
      vecs[6] = '{1, 6,    7,   1, 0, 0, 7,    1};
      vecs[7] = '{0, 5,    0,   3, 0, 1, 0,    0};
      vecs[8] = '{3, 764,  255, 0, 0, 0, 765,  1};

      @(negedge clk);
      check_reset("rst1");
      @(negedge clk);
      check_reset("rst2");
      rstn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", int'(busy), 0);
         chk("idle_re", int'(mem_re), 0);
         chk("idle_valid", int'(result_valid), 0);
      end

      for (int i = 0; i < NV; i++) run_neuron(vecs[i]);

      // Reset in the middle of an 8-chunk evaluation with stale returns of 50.
      idle_pop = 50;
      for (int i = 0; i < (1 << AW); i++) mem_val[i] = D'(50);
      start = 1'b1; num_chunks = 8; threshold = 0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_pre_re", int'(mem_re), 1);
      chk("midrst_pre_addr", int'(mem_addr), 4);
      rstn = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rstn = 1'b0;
      run_neuron('{1, 0, 7, 0, 0, 0, 7, 1});
      idle_pop = -1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
